// File: rtl/sap_pkg.sv
// Shared types and constants for the SAP-1 program loader.
package sap_pkg;

  localparam int SAP_ADDR_W     = 4;
  localparam int SAP_DATA_W     = 8;
  localparam int SAP_MEM_DEPTH  = 16;
  localparam int SAP_MAX_CYCLES = 48;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LOAD,
    CSUM,
    FILL,
    RUN,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/sap_run_monitor.sv
// Counts RUN cycles, arbitrates halt against the cycle budget and keeps the
// sticky run_done / timeout flags. Halt beats the budget in the same cycle.
module sap_run_monitor #(
  parameter int CNT_W      = 8,
  parameter int MAX_CYCLES = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             halt,
  output logic             run_exit,
  output logic [CNT_W-1:0] cycle_count,
  output logic             run_done,
  output logic             timeout
);

  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             run_done_q, run_done_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             limit_hit;

  assign cnt_inc   = cycle_count_q + 1'b1;
  assign limit_hit = (cnt_inc == CNT_W'(MAX_CYCLES));
  assign run_exit  = en & (halt | limit_hit);

  // Next-state for counter and sticky flags.
  always_comb begin
    cycle_count_d = cycle_count_q;
    run_done_d    = run_done_q;
    timeout_d     = timeout_q;
    if (clear) begin
      cycle_count_d = '0;
      run_done_d    = 1'b0;
      timeout_d     = 1'b0;
    end else if (en) begin
      cycle_count_d = cnt_inc;
      if (halt) begin
        run_done_d = 1'b1;
      end else if (limit_hit) begin
        timeout_d = 1'b1;
      end
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count_q <= '0;
      run_done_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      cycle_count_q <= cycle_count_d;
      run_done_q    <= run_done_d;
      timeout_q     <= timeout_d;
    end
  end

  assign cycle_count = cycle_count_q;
  assign run_done    = run_done_q;
  assign timeout     = timeout_q;

endmodule

// File: rtl/sap_program_loader.sv
// Loads a length/data/checksum byte stream into the SAP-1 RAM, zero-fills
// the unused tail, then releases the CPU and supervises its run.
module sap_program_loader
  import sap_pkg::*;
#(
  parameter int ADDR_W     = SAP_ADDR_W,
  parameter int DATA_W     = SAP_DATA_W,
  parameter int MEM_DEPTH  = SAP_MEM_DEPTH,
  parameter int MAX_CYCLES = SAP_MAX_CYCLES,
  parameter int CNT_W      = 8
) (
  input  logic              sap_clock,
  input  logic              sap_reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_reset,
  input  logic              halt,
  output logic              busy,
  output logic              run_done,
  output logic              timeout,
  output logic              len_err,
  output logic              csum_err,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  // A length byte is legal when it names 1..MEM_DEPTH words.
  function automatic logic len_legal(input logic [ADDR_W:0] l);
    return (l != '0) && (l <= DEPTH_L);
  endfunction

  loader_state_t     state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              in_ready_q, in_ready_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              len_err_q, len_err_d;
  logic              csum_err_q, csum_err_d;

  logic              beat;
  logic              start_acc;
  logic              last_beat;
  logic [DATA_W-1:0] csum_sum;
  logic              run_en;
  logic              run_exit;

  assign beat      = in_valid & in_ready_q;
  assign start_acc = start & ((state_q == IDLE) | (state_q == DONE) | (state_q == ERROR));
  assign last_beat = (((ADDR_W+1)'(addr_q)) + 1'b1) == len_q;
  assign csum_sum  = sum_q + in_data;
  assign run_en    = (state_q == RUN);

  sap_run_monitor #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_run_monitor (
    .clk         (sap_clock),
    .rst         (sap_reset),
    .clear       (start_acc),
    .en          (run_en),
    .halt        (halt),
    .run_exit    (run_exit),
    .cycle_count (cycle_count),
    .run_done    (run_done),
    .timeout     (timeout)
  );

  // Loader FSM: next state, datapath updates and registered-output values.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    addr_d      = addr_q;
    sum_d       = sum_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    len_err_d   = len_err_q;
    csum_err_d  = csum_err_q;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d    = LEN;
          len_err_d  = 1'b0;
          csum_err_d = 1'b0;
        end
      end
      LEN: begin
        if (beat) begin
          if (!len_legal(in_data[ADDR_W:0])) begin
            state_d   = ERROR;
            len_err_d = 1'b1;
          end else begin
            len_d   = in_data[ADDR_W:0];
            addr_d  = '0;
            sum_d   = '0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (beat) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = addr_q;
          ram_wdata_d = in_data;
          sum_d       = sum_q + in_data;
          addr_d      = addr_q + 1'b1;
          if (last_beat) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (beat) begin
          if (csum_sum == '0) begin
            if (len_q == DEPTH_L) begin
              state_d = RUN;
            end else begin
              // First fill write is issued on entry so ram_we is high
              // exactly on the FILL cycles.
              state_d     = FILL;
              ram_we_d    = 1'b1;
              ram_addr_d  = len_q[ADDR_W-1:0];
              ram_wdata_d = '0;
            end
          end else begin
            state_d    = ERROR;
            csum_err_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (ram_addr_q == LAST_ADDR) begin
          state_d = RUN;
        end else begin
          ram_we_d    = 1'b1;
          ram_addr_d  = ram_addr_q + 1'b1;
          ram_wdata_d = '0;
        end
      end
      RUN: begin
        if (run_exit) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == LEN) | (state_d == LOAD) | (state_d == CSUM);
    busy_d      = !((state_d == IDLE) | (state_d == DONE) | (state_d == ERROR));
    cpu_reset_d = (state_d != RUN);
  end

  // Control state and registered outputs.
  always_ff @(posedge sap_clock) begin
    if (sap_reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      len_err_q   <= 1'b0;
      csum_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      len_err_q   <= len_err_d;
      csum_err_q  <= csum_err_d;
    end
  end

  // Image length, write pointer and running sum; always rewritten before use.
  always_ff @(posedge sap_clock) begin
    len_q  <= len_d;
    addr_q <= addr_d;
    sum_q  <= sum_d;
  end

  assign in_ready  = in_ready_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign len_err   = len_err_q;
  assign csum_err  = csum_err_q;

endmodule

// File: tb/tb_sap_program_loader.sv
// Scoreboard bench for sap_program_loader: expected RAM writes are queued as
// the stream is driven and popped as the loader writes.
module tb_sap_program_loader;

  logic       sap_clock = 1'b0;
  logic       sap_reset = 1'b1;
  logic       start     = 1'b0;
  logic       in_valid  = 1'b0;
  logic [7:0] in_data   = 8'h00;
  logic       halt      = 1'b0;
  logic       in_ready, ram_we, cpu_reset, busy;
  logic       run_done, timeout, len_err, csum_err;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] cycle_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cpu_low = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  img[16];

  sap_program_loader dut (
    .sap_clock   (sap_clock),
    .sap_reset   (sap_reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .cpu_reset   (cpu_reset),
    .halt        (halt),
    .busy        (busy),
    .run_done    (run_done),
    .timeout     (timeout),
    .len_err     (len_err),
    .csum_err    (csum_err),
    .cycle_count (cycle_count)
  );

  always #5 sap_clock = ~sap_clock;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard and RUN-cycle counter, sampled on the falling edge.
  always @(negedge sap_clock) begin
    logic [11:0] e;
    if (!cpu_reset) cpu_low++;
    if (ram_we) begin
      if (exp_q.size() == 0) begin
        chk_eq("we_pending", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk_eq("wr_addr", {28'h0, ram_addr}, {28'h0, e[11:8]});
        chk_eq("wr_data", {24'h0, ram_wdata}, {24'h0, e[7:0]});
      end
    end
  end

  task automatic pulse_start();
    @(negedge sap_clock);
    start = 1'b1;
    @(posedge sap_clock);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge sap_clock);
    while (!in_ready && t < 50) begin
      @(negedge sap_clock);
      t++;
    end
    if (!in_ready) chk_eq("ready_wait", {31'h0, in_ready}, 1);
    @(posedge sap_clock);
    #1 in_valid = 1'b0;
  endtask

  function automatic logic [7:0] calc_chk(input int n);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < n; i++) s = s + img[i];
    return 8'h00 - s;
  endfunction

  task automatic send_image(input int n, input logic [7:0] len_b, input logic [7:0] chk_b,
                            input bit gaps, input bit good);
    send_byte(len_b);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({4'(i), img[i]});
      send_byte(img[i]);
      if (gaps) begin
        @(posedge sap_clock);
        #1;
      end
    end
    if (good) begin
      for (int a = n; a < 16; a++) exp_q.push_back({4'(a), 8'h00});
    end
    send_byte(chk_b);
  endtask

  // Leaves on the falling edge of the first RUN cycle.
  task automatic wait_run();
    int t = 0;
    @(negedge sap_clock);
    while (cpu_reset && t < 200) begin
      @(negedge sap_clock);
      t++;
    end
    if (cpu_reset) chk_eq("run_wait", {31'h0, cpu_reset}, 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge sap_clock);
    while (busy && t < 300) begin
      @(negedge sap_clock);
      t++;
    end
    if (busy) chk_eq("idle_wait", {31'h0, busy}, 0);
  endtask

  task automatic halt_on_cycle(input int n);
    repeat (n - 1) @(negedge sap_clock);
    halt = 1'b1;
    @(posedge sap_clock);
    #1 halt = 1'b0;
    @(negedge sap_clock);
  endtask

  task automatic check_reset_vals(input string p);
    chk_eq({p, "_in_ready"}, {31'h0, in_ready}, 0);
    chk_eq({p, "_ram_we"}, {31'h0, ram_we}, 0);
    chk_eq({p, "_ram_addr"}, {28'h0, ram_addr}, 0);
    chk_eq({p, "_ram_wdata"}, {24'h0, ram_wdata}, 0);
    chk_eq({p, "_cpu_reset"}, {31'h0, cpu_reset}, 1);
    chk_eq({p, "_busy"}, {31'h0, busy}, 0);
    chk_eq({p, "_flags"}, {28'h0, run_done, timeout, len_err, csum_err}, 0);
    chk_eq({p, "_cycles"}, {24'h0, cycle_count}, 0);
  endtask

  initial begin
    int c0;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    repeat (2) @(posedge sap_clock);
    @(negedge sap_clock);
    check_reset_vals("rst");
    sap_reset = 1'b0;

    // 1: good partial image, halt on the 10th RUN cycle
    img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0;
    c0 = cpu_low;
    pulse_start();
    chk_eq("t1_busy", {31'h0, busy}, 1);
    send_image(3, 8'h03, 8'hD3, 1'b0, 1'b1);
    wait_run();
    chk_eq("t1_ready_run", {31'h0, in_ready}, 0);
    halt_on_cycle(10);
    chk_eq("t1_run_done", {31'h0, run_done}, 1);
    chk_eq("t1_timeout", {31'h0, timeout}, 0);
    chk_eq("t1_cycles", {24'h0, cycle_count}, 10);
    chk_eq("t1_cpu_reset", {31'h0, cpu_reset}, 1);
    chk_eq("t1_run_len", cpu_low - c0, 10);
    chk_eq("t1_q_empty", exp_q.size(), 0);

    // 2: bad checksum
    c0 = cpu_low;
    pulse_start();
    chk_eq("t2_cleared", {30'h0, run_done, cycle_count == 8'h00}, 1);
    send_image(3, 8'h03, 8'hD4, 1'b0, 1'b0);
    @(negedge sap_clock);
    chk_eq("t2_csum_err", {31'h0, csum_err}, 1);
    chk_eq("t2_busy", {31'h0, busy}, 0);
    chk_eq("t2_in_ready", {31'h0, in_ready}, 0);
    repeat (20) @(negedge sap_clock);
    chk_eq("t2_cycles", {24'h0, cycle_count}, 0);
    chk_eq("t2_cpu_low", cpu_low - c0, 0);
    chk_eq("t2_q_empty", exp_q.size(), 0);

    // 3: illegal lengths 0 and 17
    pulse_start();
    chk_eq("t3_csum_clr", {31'h0, csum_err}, 0);
    send_byte(8'h00);
    @(negedge sap_clock);
    chk_eq("t3_len0_err", {31'h0, len_err}, 1);
    chk_eq("t3_len0_rdy", {31'h0, in_ready}, 0);
    pulse_start();
    chk_eq("t3_len_clr", {31'h0, len_err}, 0);
    send_byte(8'h11);
    @(negedge sap_clock);
    chk_eq("t3_len17_err", {31'h0, len_err}, 1);
    chk_eq("t3_len17_rdy", {31'h0, in_ready}, 0);
    chk_eq("t3_len17_busy", {31'h0, busy}, 0);

    // 4: full image, halt held low until timeout
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(0, 255));
    c0 = cpu_low;
    pulse_start();
    send_image(16, 8'h10, calc_chk(16), 1'b0, 1'b1);
    wait_idle();
    chk_eq("t4_timeout", {31'h0, timeout}, 1);
    chk_eq("t4_run_done", {31'h0, run_done}, 0);
    chk_eq("t4_cycles", {24'h0, cycle_count}, 48);
    chk_eq("t4_run_len", cpu_low - c0, 48);
    chk_eq("t4_q_empty", exp_q.size(), 0);

    // 5: gapped load, stray bytes in RUN, halt on the budget cycle
    for (int i = 0; i < 5; i++) img[i] = 8'($urandom_range(0, 255));
    pulse_start();
    send_image(5, 8'h05, calc_chk(5), 1'b1, 1'b1);
    wait_run();
    in_valid = 1'b1;
    in_data  = 8'h55;
    chk_eq("t5_ready_run", {31'h0, in_ready}, 0);
    halt_on_cycle(48);
    in_valid = 1'b0;
    chk_eq("t5_run_done", {31'h0, run_done}, 1);
    chk_eq("t5_timeout", {31'h0, timeout}, 0);
    chk_eq("t5_cycles", {24'h0, cycle_count}, 48);
    chk_eq("t5_q_empty", exp_q.size(), 0);

    // 6: reset after two of five data bytes, then a clean reload
    for (int i = 0; i < 5; i++) img[i] = 8'($urandom_range(0, 255));
    pulse_start();
    send_byte(8'h05);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({4'(i), img[i]});
      send_byte(img[i]);
    end
    @(negedge sap_clock);
    sap_reset = 1'b1;
    @(posedge sap_clock);
    #1 sap_reset = 1'b0;
    @(negedge sap_clock);
    check_reset_vals("t6_rst");
    chk_eq("t6_q_empty_rst", exp_q.size(), 0);
    pulse_start();
    send_image(5, 8'h05, calc_chk(5), 1'b0, 1'b1);
    wait_run();
    halt_on_cycle(4);
    chk_eq("t6_run_done", {31'h0, run_done}, 1);
    chk_eq("t6_cycles", {24'h0, cycle_count}, 4);
    chk_eq("t6_q_empty", exp_q.size(), 0);

    repeat (2) @(negedge sap_clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sap_program_loader.md
Name: sap_program_loader

Overview:
Front-end that writes a program image into the SAP-1 16x8 RAM from a byte stream. It holds the CPU in reset while loading, validates the image, releases the CPU to run, and watches halt. It is the writer and supervisor for the memory that the SAP core reads and executes. It sits between a host byte source (UART or bench) and the SAP RAM write port and reset input.

Parameters:
ADDR_W, 4, RAM address width
DATA_W, 8, RAM word / stream byte width
MEM_DEPTH, 16, RAM words; must equal 2**ADDR_W
MAX_CYCLES, 48, run-cycle budget before timeout
CNT_W, 8, cycle_count width; must hold MAX_CYCLES

Ports:
sap_clock  in  1  system clock, all state on rising edge
sap_reset  in  1  synchronous active-high reset
start  in  1  pulse: begin load sequence
in_valid  in  1  stream byte valid
in_data  in  DATA_W  stream byte
in_ready  out  1  loader accepts byte (beat = in_valid & in_ready)
ram_we  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM write address
ram_wdata  out  DATA_W  RAM write data
cpu_reset  out  1  reset to SAP core, high = held
halt  in  1  SAP halt flag
busy  out  1  high in any state except IDLE/DONE/ERROR
run_done  out  1  sticky: CPU halted within budget
timeout  out  1  sticky: budget exhausted without halt
len_err  out  1  sticky: illegal length byte
csum_err  out  1  sticky: checksum mismatch
cycle_count  out  CNT_W  RUN cycles elapsed

Behaviour:
- Interface: one clock, sap_clock. Reset sap_reset is synchronous and active-high.
- Reset values, also applied when sap_reset is asserted mid-operation:
  - state IDLE
  - cpu_reset=1
  - in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0
  - busy=0, cycle_count=0, all sticky flags 0
  - RAM contents are not touched.
- Stream format: LEN byte, then LEN data bytes, then CHK byte.
  - LEN uses in_data[4:0]; legal range 1..16.
  - CHK is chosen so that the mod-256 sum of all data bytes plus CHK equals 0x00.
- All outputs are registered. in_ready is high only in LEN, LOAD and CSUM. In_valid is ignored whenever in_ready=0.
- IDLE/DONE/ERROR: start=1 moves to LEN and clears all sticky flags and cycle_count. start is ignored while busy.
- LEN, on a beat:
  - LEN==0 or LEN>16: go to ERROR, len_err=1.
  - Otherwise latch len, set addr=0 and sum=0, go to LOAD.
- LOAD, on each beat:
  - ram_we=1 with ram_addr=addr and ram_wdata=in_data, asserted the following cycle (1-cycle latency).
  - sum += in_data (8-bit wrap); addr increments.
  - After len beats, go to CSUM.
  - No beat means no write; ram_we=0 on gap cycles.
- CSUM, on a beat:
  - If (sum+in_data)[7:0]==0: go to FILL when len<16, or RUN when len==16.
  - Otherwise go to ERROR, csum_err=1.
- FILL:
  - in_ready=0.
  - Write 0x00 to addresses len..15, one per cycle, ram_we high continuously.
  - Go to RUN after address 15 is written. No wrap to address 0.
- RUN:
  - cpu_reset=0 on every RUN cycle; cpu_reset=1 in all other states.
  - cycle_count increments on every RUN cycle, including the exit cycle.
  - halt=1 goes to DONE with run_done=1.
  - Otherwise, when cycle_count reaches MAX_CYCLES, go to DONE with timeout=1.
  - If halt and the budget limit occur in the same cycle, halt wins: run_done=1, timeout=0.
  - halt is ignored outside RUN.
- DONE/ERROR: cpu_reset=1, flags held, cycle_count held.
- ram_we is never high in IDLE, LEN, CSUM, RUN, DONE or ERROR (except the trailing write of the last LOAD beat).

Decomposition:
- Package sap_pkg holds:
  - loader_state_t enum {IDLE, LEN, LOAD, CSUM, FILL, RUN, DONE, ERROR}
  - constants SAP_ADDR_W=4, SAP_DATA_W=8, SAP_MEM_DEPTH=16, SAP_MAX_CYCLES=48
- One sub-module, sap_run_monitor. It contains the RUN cycle counter, halt/timeout arbitration and the run_done/timeout flags, with an enable input from the FSM.

Test Plan:
1. Good load, partial image:
   - Stimulus: start; stream 0x03, 0x1E, 0x2F, 0xE0, CHK 0xD3; halt pulsed on the 10th RUN cycle.
   - Response: writes addr0..2 = 0x1E, 0x2F, 0xE0; then 13 zero writes to addr 3..15; cpu_reset drops; run_done=1, cycle_count=10, cpu_reset back to 1.
2. Bad checksum:
   - Stimulus: same stream with CHK 0xD4.
   - Response: csum_err=1, state ERROR, no FILL writes, cpu_reset never deasserts, cycle_count=0.
3. Length errors:
   - Stimulus: LEN=0x00, then (after a new start) LEN=0x11.
   - Response: len_err=1 each time, no ram_we, in_ready=0 afterwards.
4. Full image and timeout:
   - Stimulus: LEN=0x10 with 16 bytes and correct CHK; halt held low.
   - Response: no FILL cycles; RUN entered; timeout=1 at cycle_count=48; run_done=0.
5. Backpressure and stray traffic:
   - Stimulus: in_valid toggled 1/0 during LOAD; in_valid=1 during RUN.
   - Response: exactly len writes with contiguous addresses; RUN bytes ignored, in_ready=0.
   - Stimulus: halt together with the 48th RUN cycle.
   - Response: run_done=1, timeout=0.
6. Reset mid-load:
   - Stimulus: sap_reset for 1 cycle after 2 of 5 data bytes.
   - Response: all outputs at reset values next edge, cpu_reset=1; a following start and good stream loads and runs correctly.
